// File: rtl/fft_bfly_pipe.sv
// fft_bfly_pipe: pipelined array of LANES radix-2 DIT butterflies in signed
// Q-format fixed point.
//   y0 = x0 + x1*tw,  y1 = x0 - x1*tw   (per lane, complex)
// Three register stages share one enable (en = !out_valid || out_ready):
//   S1: registers x0 and scale_en, and forms the four complex partial products.
//   S2: rounds each product sum half-up by 2^Q and clips it to N+1 bits.
//   S3: forms the sum and the difference, optionally halves them
//       (rounding half-up), clips to N bits and loads the outputs.
// The ovf flag is sticky: it sets on any clipped component that is loaded
// into S3 and clears on ovf_clr. If a set and a clear arrive together, the
// set wins.
//
// Optional feature macro: FFT_BFLY_CONJ_EN. When it is defined, the block
// has an extra input conj_tw, and conj_tw=1 negates tw_i before the multiply.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    input handshake (in_ready is combinational)
//   scale_en               halve both results of this transfer
//   conj_tw                (FFT_BFLY_CONJ_EN only) conjugate the twiddle
//   x0_r/x0_i/x1_r/x1_i    butterfly inputs, lane k at [k*N +: N]
//   tw_r/tw_i              twiddle factor for each lane
//   out_valid / out_ready  output handshake
//   y0_r/y0_i/y1_r/y1_i    registered butterfly outputs
//   ovf / ovf_clr          sticky saturation flag and its synchronous clear
module fft_bfly_pipe #(
    parameter int N     = 16,
    parameter int Q     = 8,
    parameter int LANES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               scale_en,
`ifdef FFT_BFLY_CONJ_EN
    input  logic               conj_tw,
`endif
    input  logic [LANES*N-1:0] x0_r,
    input  logic [LANES*N-1:0] x0_i,
    input  logic [LANES*N-1:0] x1_r,
    input  logic [LANES*N-1:0] x1_i,
    input  logic [LANES*N-1:0] tw_r,
    input  logic [LANES*N-1:0] tw_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*N-1:0] y0_r,
    output logic [LANES*N-1:0] y0_i,
    output logic [LANES*N-1:0] y1_r,
    output logic [LANES*N-1:0] y1_i,
    output logic               ovf,
    input  logic               ovf_clr
);

    // The products use N x (N+1) bits, so that a negated tw_i of -2^(N-1)
    // still fits in the operand.
    localparam int PW    = 2*N + 1;
    localparam int TW    = N + 1;
    localparam int SW    = N + 3;
    localparam int RHALF = 1 << (Q - 1);

    localparam logic signed [PW:0]   TMAX = {{(PW+1-N){1'b0}}, {N{1'b1}}};
    localparam logic signed [PW:0]   TMIN = {{(PW+1-N){1'b1}}, {N{1'b0}}};
    localparam logic signed [SW-1:0] OMAX = {{(SW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [SW-1:0] OMIN = {{(SW-N+1){1'b1}}, {(N-1){1'b0}}};

    // Rounds half-up by 2^Q and clips to N+1 bits. The result is {clip, value}.
    function automatic logic [TW:0] rnd_sat(input logic signed [PW:0] v);
        logic signed [PW:0] s;
        s = (v + (PW+1)'(RHALF)) >>> Q;
        if (s > TMAX) return {1'b1, TMAX[TW-1:0]};
        if (s < TMIN) return {1'b1, TMIN[TW-1:0]};
        return {1'b0, s[TW-1:0]};
    endfunction

    // Forms a +/- t, optionally halves it (rounding half-up), and clips it
    // to N bits. The result is {clip, value}.
    function automatic logic [N:0] add_sat(input logic signed [N-1:0]  a,
                                           input logic signed [TW-1:0] t,
                                           input logic                 sub,
                                           input logic                 sc);
        logic signed [SW-1:0] v;
        v = sub ? (SW'(a) - SW'(t)) : (SW'(a) + SW'(t));
        if (sc) v = (v + SW'(1)) >>> 1;
        if (v > OMAX) return {1'b1, OMAX[N-1:0]};
        if (v < OMIN) return {1'b1, OMIN[N-1:0]};
        return {1'b0, v[N-1:0]};
    endfunction

    logic en;
    logic out_valid_q;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = rst_n && en;

    // Stage 1 state
    logic                 v1_q, sc1_q;
    logic signed [N-1:0]  s1_x0r_q [LANES];
    logic signed [N-1:0]  s1_x0i_q [LANES];
    logic signed [PW-1:0] rr_q [LANES], ii_q [LANES], ri_q [LANES], ir_q [LANES];
    logic signed [PW-1:0] rr_d [LANES], ii_d [LANES], ri_d [LANES], ir_d [LANES];

    // Stage 2 state
    logic                 v2_q, sc2_q;
    logic signed [N-1:0]  s2_x0r_q [LANES];
    logic signed [N-1:0]  s2_x0i_q [LANES];
    logic signed [TW-1:0] tr_q [LANES], ti_q [LANES];
    logic signed [TW-1:0] tr_d [LANES], ti_d [LANES];
    logic                 clip2_q [LANES];
    logic                 clip2_d [LANES];

    // Stage 3 (output) state
    logic [LANES*N-1:0] y0r_q, y0i_q, y1r_q, y1i_q;
    logic [LANES*N-1:0] y0r_d, y0i_d, y1r_d, y1i_d;
    logic               clip3_d;
    logic               ovf_q, ovf_d;

    // S1: form the products.
    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            logic signed [N-1:0] xr, xi, wr;
            logic signed [N:0]   wi;
            xr = $signed(x1_r[k*N +: N]);
            xi = $signed(x1_i[k*N +: N]);
            wr = $signed(tw_r[k*N +: N]);
            wi = TW'($signed(tw_i[k*N +: N]));
`ifdef FFT_BFLY_CONJ_EN
            if (conj_tw) wi = -wi;
`endif
            rr_d[k] = PW'(xr) * PW'(wr);
            ii_d[k] = PW'(xi) * PW'(wi);
            ri_d[k] = PW'(xr) * PW'(wi);
            ir_d[k] = PW'(xi) * PW'(wr);
        end
    end

    // S2: round and clip the real and imaginary parts of x1*tw.
    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            logic [TW:0] r, i;
            r = rnd_sat((PW+1)'(rr_q[k]) - (PW+1)'(ii_q[k]));
            i = rnd_sat((PW+1)'(ri_q[k]) + (PW+1)'(ir_q[k]));
            tr_d[k]    = $signed(r[TW-1:0]);
            ti_d[k]    = $signed(i[TW-1:0]);
            clip2_d[k] = r[TW] | i[TW];
        end
    end

    // S3: form the butterfly outputs. Clipping that already happened in S2
    // is counted here as well, because the flag tracks results loaded into S3.
    always_comb begin
        y0r_d   = '0;
        y0i_d   = '0;
        y1r_d   = '0;
        y1i_d   = '0;
        clip3_d = 1'b0;
        for (int unsigned k = 0; k < LANES; k++) begin
            logic [N:0] a, b, c, d;
            a = add_sat(s2_x0r_q[k], tr_q[k], 1'b0, sc2_q);
            b = add_sat(s2_x0i_q[k], ti_q[k], 1'b0, sc2_q);
            c = add_sat(s2_x0r_q[k], tr_q[k], 1'b1, sc2_q);
            d = add_sat(s2_x0i_q[k], ti_q[k], 1'b1, sc2_q);
            y0r_d[k*N +: N] = a[N-1:0];
            y0i_d[k*N +: N] = b[N-1:0];
            y1r_d[k*N +: N] = c[N-1:0];
            y1i_d[k*N +: N] = d[N-1:0];
            clip3_d = clip3_d | a[N] | b[N] | c[N] | d[N] | clip2_q[k];
        end
    end

    always_comb begin
        ovf_d = ovf_q & ~ovf_clr;
        if (en && v2_q && clip3_d) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            sc1_q       <= 1'b0;
            v2_q        <= 1'b0;
            sc2_q       <= 1'b0;
            out_valid_q <= 1'b0;
            y0r_q       <= '0;
            y0i_q       <= '0;
            y1r_q       <= '0;
            y1i_q       <= '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                s1_x0r_q[k] <= '0;
                s1_x0i_q[k] <= '0;
                rr_q[k]     <= '0;
                ii_q[k]     <= '0;
                ri_q[k]     <= '0;
                ir_q[k]     <= '0;
                s2_x0r_q[k] <= '0;
                s2_x0i_q[k] <= '0;
                tr_q[k]     <= '0;
                ti_q[k]     <= '0;
                clip2_q[k]  <= 1'b0;
            end
        end else if (en) begin
            v1_q        <= in_valid;
            sc1_q       <= scale_en;
            v2_q        <= v1_q;
            sc2_q       <= sc1_q;
            out_valid_q <= v2_q;
            for (int unsigned k = 0; k < LANES; k++) begin
                s1_x0r_q[k] <= $signed(x0_r[k*N +: N]);
                s1_x0i_q[k] <= $signed(x0_i[k*N +: N]);
                rr_q[k]     <= rr_d[k];
                ii_q[k]     <= ii_d[k];
                ri_q[k]     <= ri_d[k];
                ir_q[k]     <= ir_d[k];
                s2_x0r_q[k] <= s1_x0r_q[k];
                s2_x0i_q[k] <= s1_x0i_q[k];
                tr_q[k]     <= tr_d[k];
                ti_q[k]     <= ti_d[k];
                clip2_q[k]  <= clip2_d[k];
            end
            // The outputs keep the last result when a bubble reaches S3.
            if (v2_q) begin
                y0r_q <= y0r_d;
                y0i_q <= y0i_d;
                y1r_q <= y1r_d;
                y1i_q <= y1i_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign out_valid = out_valid_q;
    assign y0_r      = y0r_q;
    assign y0_i      = y0i_q;
    assign y1_r      = y1r_q;
    assign y1_i      = y1i_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_bfly_pipe.sv
// Directed testbench for fft_bfly_pipe with N=16, Q=8 and LANES=2.
// The expected values are worked out by hand from the butterfly equations.
module tb_fft_bfly_pipe;

    localparam int N     = 16;
    localparam int Q     = 8;
    localparam int LANES = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid, in_ready, scale_en;
    logic [LANES*N-1:0] x0_r, x0_i, x1_r, x1_i, tw_r, tw_i;
    logic               out_valid, out_ready;
    logic [LANES*N-1:0] y0_r, y0_i, y1_r, y1_i;
    logic               ovf, ovf_clr;
`ifdef FFT_BFLY_CONJ_EN
    logic               conj_tw = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fft_bfly_pipe #(.N(N), .Q(Q), .LANES(LANES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .scale_en  (scale_en),
`ifdef FFT_BFLY_CONJ_EN
        .conj_tw   (conj_tw),
`endif
        .x0_r      (x0_r),
        .x0_i      (x0_i),
        .x1_r      (x1_r),
        .x1_i      (x1_i),
        .tw_r      (tw_r),
        .tw_i      (tw_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0_r      (y0_r),
        .y0_i      (y0_i),
        .y1_r      (y1_r),
        .y1_i      (y1_i),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    function automatic logic signed [31:0] ln(input logic [LANES*N-1:0] bus, input int k);
        return 32'($signed(bus[k*N +: N]));
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int k, input int a0r, input int a0i, input int a1r,
                            input int a1i, input int wr, input int wi);
        x0_r[k*N +: N] = a0r[N-1:0];
        x0_i[k*N +: N] = a0i[N-1:0];
        x1_r[k*N +: N] = a1r[N-1:0];
        x1_i[k*N +: N] = a1i[N-1:0];
        tw_r[k*N +: N] = wr[N-1:0];
        tw_i[k*N +: N] = wi[N-1:0];
    endtask

    task automatic chk_lane(input string tag, input int k, input int e0r, input int e0i,
                            input int e1r, input int e1i);
        chk({tag, "_y0r"}, ln(y0_r, k), e0r);
        chk({tag, "_y0i"}, ln(y0_i, k), e0i);
        chk({tag, "_y1r"}, ln(y1_r, k), e1r);
        chk({tag, "_y1i"}, ln(y1_i, k), e1i);
    endtask

    // Offers one transfer, then waits (for at most 10 edges) until the
    // result appears.
    task automatic xfer(input string tag);
        int lat;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 3);
    endtask

    initial begin
        int sent, recv, bp_err, stall_err, stall_cnt, stale;
        logic stall_prev;
        logic [LANES*N-1:0] y_hold;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        scale_en  = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        x0_r = '0; x0_i = '0; x1_r = '0; x1_i = '0; tw_r = '0; tw_i = '0;

        // The block is held in reset.
        #3;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_y0r", ln(y0_r, 0), 0);
        chk("rst_ovf", 32'(ovf), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // Unity butterfly on lane 0; lane 1 gets other data.
        set_lane(0, 256, 0, 256, 0, 256, 0);
        set_lane(1, 100, 50, 256, 256, 256, 0);
        xfer("unity");
        chk_lane("unity_l0", 0, 512, 0, 0, 0);
        chk_lane("unity_l1", 1, 356, 306, -156, -206);

        // Twiddle of -j on lane 0; lane 1 computes j*j.
        set_lane(0, 256, 0, 256, 0, 0, -256);
        set_lane(1, 0, 0, 0, 256, 0, 256);
        xfer("twj");
        chk_lane("twj_l0", 0, 256, -256, 256, 256);
        chk_lane("twj_l1", 1, -256, 0, 256, 0);

        // Rounding half-up: +0.5 LSB rounds to 1 and -0.5 LSB rounds to 0.
        set_lane(0, 0, 0, 1, 0, 128, 0);
        set_lane(1, 0, 0, -1, 0, 128, 0);
        xfer("round");
        chk_lane("round_l0", 0, 1, 0, -1, 0);
        chk_lane("round_l1", 1, 0, 0, 0, 0);

        // Halving, rounded half-up.
        scale_en = 1'b1;
        set_lane(0, 513, 0, 0, 0, 0, 0);
        set_lane(1, -3, 0, 0, 0, 0, 0);
        xfer("scale");
        scale_en = 1'b0;
        chk_lane("scale_l0", 0, 257, 0, 257, 0);
        chk_lane("scale_l1", 1, -1, 0, -1, 0);
        chk("no_ovf_yet", 32'(ovf), 0);

        // Positive saturation sets the sticky flag.
        set_lane(0, 32767, 0, 256, 0, 256, 0);
        set_lane(1, 0, 0, 0, 0, 0, 0);
        xfer("sat");
        chk_lane("sat_l0", 0, 32767, 0, 32511, 0);
        chk("sat_ovf", 32'(ovf), 1);
        @(posedge clk); #1;
        chk("ovf_sticky", 32'(ovf), 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("ovf_cleared", 32'(ovf), 0);

        // A clear that arrives together with a new overflow leaves ovf set.
        // Lane 1 saturates negative.
        ovf_clr = 1'b1;
        set_lane(1, -32768, 0, 256, 0, 256, 0);
        xfer("coinc");
        chk("coinc_ovf", 32'(ovf), 1);
        ovf_clr = 1'b0;
        chk_lane("coinc_l1", 1, -32512, 0, -32768, 0);
        @(posedge clk); #1;

        // Backpressure: eight transfers, with out_ready low in cycles 4-8.
        sent = 0; recv = 0; bp_err = 0; stall_err = 0; stall_cnt = 0;
        stall_prev = 1'b0; y_hold = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 8);
            in_valid  = (sent < 8);
            set_lane(0, 10 + sent, -sent, 0, 0, 0, 0);
            set_lane(1, 20 + sent, sent, 0, 0, 0, 0);
            #1;
            if (out_valid && !out_ready) begin
                stall_cnt++;
                if (in_ready) bp_err++;
            end
            if (stall_prev && y0_r !== y_hold) stall_err++;
            if (out_valid && out_ready) begin
                chk("bp_y0r_l0", ln(y0_r, 0), 10 + recv);
                chk("bp_y1i_l1", ln(y1_i, 1), recv);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            stall_prev = out_valid && !out_ready;
            y_hold     = y0_r;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_received", recv, 8);
        chk("bp_in_ready_low", bp_err, 0);
        chk("bp_stall_stable", stall_err, 0);
        chk("bp_stall_cycles", stall_cnt, 5);

        // Reset with two results in flight; ovf is still set at this point.
        set_lane(0, 1000, 0, 256, 0, 256, 0);
        set_lane(1, 1000, 0, 256, 0, 256, 0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_ovf", 32'(ovf), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_y0r", ln(y0_r, 0), 0);
        chk("mid_rst_y1i", ln(y1_i, 1), 0);
        chk("mid_rst_ovf", 32'(ovf), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stale = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        chk("no_stale_out", stale, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
